dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data RAM between the CPU_Core data port and a debug/loader port.
//  CPU has default priority; a saturating starvation counter guarantees debug progress.
//  Losing requesters are held off: the CPU through a stall, debug through withheld grant.
//  Sits between CPU_Core (address/write_data_DMEM, MemRead/MemWrite) and RAM; the RAM has async read and a posedge write.
// PARAMETERS
//  AW          10  word-address width (matches RAM)
//  DW          32  data width
//  STARVE_MAX  4   consecutive CPU wins tolerated while dbg_req pending (>=1)
//  BURST_MAX   8   max consecutive locked debug grants before forced release (>=1)
// PORTS
//  CLK         in   1   clock, rising edge
//  RSTn        in   1   asynchronous active-low reset
//  cpu_re      in   1   CPU read request (MemRead)
//  cpu_we      in   1   CPU write request (MemWrite)
//  cpu_addr    in   AW  CPU address
//  cpu_wdata   in   DW  CPU write data
//  cpu_rdata   out  DW  CPU read data (combinational)
//  cpu_stall   out  1   CPU must hold PC/regfile this cycle
//  dbg_req     in   1   debug access request
//  dbg_we      in   1   1=write, 0=read
//  dbg_lock    in   1   keep ownership for following cycles (burst)
//  dbg_addr    in   AW  debug address
//  dbg_wdata   in   DW  debug write data
//  dbg_gnt     out  1   debug access performed this cycle
//  dbg_rdata   out  DW  registered debug read data
//  dbg_rvalid  out  1   dbg_rdata valid (1 cycle after granted read)
//  mem_re/mem_we out 1  to RAM MemRead/MemWrite
//  mem_addr    out  AW  to RAM
//  mem_wdata   out  DW  to RAM
//  mem_rdata   in   DW  from RAM
// BEHAVIOUR
//  cpu_req = cpu_re|cpu_we. Grant is combinational per cycle from registered state + current requests.
//  States: ARB, LOCKED, COOLDOWN. Reset: state=ARB, starve_cnt=0, burst_cnt=0, dbg_rvalid=0, dbg_rdata=0.
//  While RSTn=0: mem_re=mem_we=dbg_gnt=cpu_stall=0 (forced, independent of inputs).
//  ARB: dbg wins if dbg_req & (~cpu_req | starve_cnt==STARVE_MAX); otherwise CPU wins if cpu_req.
//    dbg wins with dbg_lock=1 -> LOCKED, burst_cnt=1. Otherwise stay in ARB.
//  LOCKED: dbg owns RAM; CPU stalls. Each dbg grant increments burst_cnt.
//    Exit to ARB when dbg_lock=0 or dbg_req=0 (that cycle is arbitrated as ARB).
//    On a grant with burst_cnt==BURST_MAX -> COOLDOWN.
//  COOLDOWN: 1 cycle; CPU wins if cpu_req, dbg held off (dbg_gnt=0) even if CPU is idle; -> ARB.
//  starve_cnt: +1 (saturating at STARVE_MAX) on each CPU grant while dbg_req=1.
//    Cleared on any dbg grant or any cycle with dbg_req=0.
//  Mux: owner drives mem_addr/mem_wdata/mem_re/mem_we. No owner: mem_re=mem_we=0, addr/wdata=0.
//  cpu_rdata = mem_rdata when CPU granted a read, else 0. cpu_stall = cpu_req & ~cpu_grant.
//  dbg_gnt = dbg grant. On a granted read, dbg_rdata<=mem_rdata at the posedge and dbg_rvalid=1 for exactly the next cycle.
//  cpu_re&cpu_we both high: treated as a write (mem_we=1, mem_re=0). Same for dbg_we.
//  Reset mid-burst: immediate return to ARB with counters cleared; a pending dbg_rvalid is dropped.
//  Simultaneous new requests in ARB with starve_cnt<STARVE_MAX: CPU wins, dbg_gnt=0.
// STRUCTURE
//  Package dmem_arb_pkg: typedef enum logic[1:0] {ARB,LOCKED,COOLDOWN} arb_state_t;
//    typedef enum logic[1:0] {OWN_NONE,OWN_CPU,OWN_DBG} owner_t.
//  Sub-module sat_counter #(MAX): clear, inc, count, at_max. Instantiated twice (starve, burst).
//  Top-level pieces: state register, grant logic, output mux, dbg read-data register.
// TESTING
//  1. CPU reads 0x010 continuously with dbg idle -> cpu_stall=0 every cycle, mem_addr=0x010, dbg_gnt never 1.
//  2. CPU requests every cycle and dbg reads 0x020 (STARVE_MAX=4) -> 4 CPU grants, then cycle 5 dbg_gnt=1
//     and cpu_stall=1; next cycle dbg_rvalid=1 with dbg_rdata=RAM[0x020].
//  3. dbg_lock held while writing 0x100..0x10F with BURST_MAX=8 and the CPU requesting -> 8 dbg grants,
//     1 COOLDOWN cycle with the CPU granted, then the burst resumes; RAM ends up holding all 16 words.
//  4. Both sides write the same address in one cycle with starve_cnt=0 -> only the CPU data lands in RAM;
//     the dbg write completes later and overwrites it.
//  5. RSTn dropped mid-burst (burst_cnt=3) -> mem_we=0 immediately; after release, state=ARB and
//     dbg_rvalid=0, and the CPU is granted on its first request.
//  6. Full Fibonacci.hex program run with random dbg reads -> the CPU result in RAM matches a run without
//     dbg traffic, and every dbg read returns the current RAM content.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg : shared types and helpers for the data-RAM arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB      = 2'd0,
        LOCKED   = 2'd1,
        COOLDOWN = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    // Bits needed to hold the values 0..max inclusive.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter : up-counter that saturates at MAX, with synchronous clear
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter
    import dmem_arb_pkg::*;
#(
    parameter int MAX = 4,
    parameter int CW  = cnt_width(MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          inc_i,
    output logic [CW-1:0] count_o,
    output logic          at_max_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign at_max_o = (count_q == CW'(MAX));
    assign count_o  = count_q;

    // Clear dominates increment.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !at_max_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter : shares the single-port data RAM between CPU and debug port
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          cpu_re,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic          dbg_lock,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_rvalid,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int SCW = cnt_width(STARVE_MAX);
    localparam int BCW = cnt_width(BURST_MAX);

    arb_state_t     state_q;
    arb_state_t     state_d;
    owner_t         owner;
    logic           cpu_req;
    logic           cpu_gnt;
    logic           dbg_win;
    logic           cpu_rd;
    logic           starve_at_max;
    logic           burst_at_max;
    logic           burst_last;
    logic [BCW-1:0] burst_cnt;
    logic [SCW-1:0] starve_cnt_unused;
    logic           dbg_rvalid_q;
    logic           dbg_rvalid_d;
    logic [DW-1:0]  dbg_rdata_q;
    logic [DW-1:0]  dbg_rdata_d;

    assign cpu_req    = cpu_re | cpu_we;
    assign cpu_rd     = cpu_re & ~cpu_we;
    // The grant about to be issued is the last one the burst may take.
    assign burst_last = burst_at_max || (burst_cnt == BCW'(BURST_MAX - 1));

    // Grant logic and next state.
    always_comb begin
        owner   = OWN_NONE;
        state_d = state_q;
        case (state_q)
            COOLDOWN: begin
                if (cpu_req) begin
                    owner = OWN_CPU;
                end
                state_d = ARB;
            end
            default: begin
                if (state_q == LOCKED && dbg_req && dbg_lock) begin
                    owner = OWN_DBG;
                end else if (dbg_req && (!cpu_req || starve_at_max)) begin
                    owner = OWN_DBG;
                end else if (cpu_req) begin
                    owner = OWN_CPU;
                end
                if (owner == OWN_DBG && dbg_lock) begin
                    state_d = burst_last ? COOLDOWN : LOCKED;
                end else begin
                    state_d = ARB;
                end
            end
        endcase
        if (!RSTn) begin
            owner   = OWN_NONE;
            state_d = ARB;
        end
    end

    assign cpu_gnt = (owner == OWN_CPU);
    assign dbg_win = (owner == OWN_DBG);

    sat_counter #(
        .MAX      (STARVE_MAX)
    ) u_starve_cnt (
        .clk      (CLK),
        .rst_n    (RSTn),
        .clear_i  (dbg_win | ~dbg_req),
        .inc_i    (cpu_gnt & dbg_req),
        .count_o  (starve_cnt_unused),
        .at_max_o (starve_at_max)
    );

    sat_counter #(
        .MAX      (BURST_MAX)
    ) u_burst_cnt (
        .clk      (CLK),
        .rst_n    (RSTn),
        .clear_i  (state_d == ARB),
        .inc_i    (dbg_win & dbg_lock),
        .count_o  (burst_cnt),
        .at_max_o (burst_at_max)
    );

    // RAM port mux; a simultaneous read+write request is treated as a write.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_rdata = '0;
        case (owner)
            OWN_CPU: begin
                mem_re    = cpu_rd;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                cpu_rdata = cpu_rd ? mem_rdata : '0;
            end
            OWN_DBG: begin
                mem_re    = ~dbg_we;
                mem_we    = dbg_we;
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
            end
            default: ;
        endcase
    end

    assign cpu_stall = RSTn & cpu_req & ~cpu_gnt;
    assign dbg_gnt   = dbg_win;

    always_comb begin
        dbg_rvalid_d = dbg_win & ~dbg_we;
        dbg_rdata_d  = dbg_rvalid_d ? mem_rdata : dbg_rdata_q;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= ARB;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter : self-checking bench for dmem_arbiter with a RAM model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

    localparam int AW      = 10;
    localparam int DW      = 32;
    localparam int SMAX    = 4;
    localparam int BMAX    = 8;
    localparam int ST_ARB  = 0;
    localparam int ST_LOCK = 1;
    localparam int ST_COOL = 2;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          cpu_re, cpu_we, cpu_stall;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic          mem_re, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;
    logic [DW-1:0] ram  [0:(1<<AW)-1];
    logic [DW-1:0] mref [0:(1<<AW)-1];

    always #5 CLK = ~CLK;

    // RAM: asynchronous read, posedge write, plus a backdoor for preloading.
    assign mem_rdata = ram[mem_addr];
    always @(posedge CLK) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    dmem_arbiter #(
        .AW(AW), .DW(DW), .STARVE_MAX(SMAX), .BURST_MAX(BMAX)
    ) dut (
        .CLK(CLK), .RSTn(RSTn),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic          rst;
        logic          cpu_stall, dbg_gnt, mem_re, mem_we;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_wdata, cpu_rdata;
        logic          dbg_rvalid;
        logic [DW-1:0] dbg_rdata;
    } obs_t;

    typedef struct {
        logic cre, cwe; logic [AW-1:0] caddr; logic [DW-1:0] cwd;
        logic dreq, dwe, dlk; logic [AW-1:0] daddr; logic [DW-1:0] dwd;
        logic x_stall, x_gnt, x_rv; logic [DW-1:0] x_rd;
    } vec_t;

    obs_t          sb_q[$];
    vec_t          tv[11];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc_n = 0;
    int            m_st, m_starve, m_burst;
    logic          m_rv;
    logic [DW-1:0] m_rd;
    logic          smp_stall, smp_gnt, smp_rvalid;
    logic [DW-1:0] smp_rdata, smp_cpu_rdata;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h, want %0h", nm, cyc_n, act, exp);
        end
    endtask

    task automatic m_reset();
        m_st = ST_ARB; m_starve = 0; m_burst = 0; m_rv = 1'b0; m_rd = '0;
    endtask

    // Reference model: compute this cycle's expected outputs, then advance.
    task automatic model_push();
        obs_t e;
        logic cg, dg, creq;
        e = '0;
        if (!RSTn) begin
            e.rst = 1'b1;
            m_reset();
            sb_q.push_back(e);
            return;
        end
        creq = cpu_re | cpu_we;
        cg = 1'b0; dg = 1'b0;
        if (m_st == ST_COOL) cg = creq;
        else if (m_st == ST_LOCK && dbg_req && dbg_lock) dg = 1'b1;
        else if (dbg_req && (!creq || m_starve == SMAX)) dg = 1'b1;
        else cg = creq;
        e.cpu_stall  = creq && !cg;
        e.dbg_gnt    = dg;
        e.dbg_rvalid = m_rv;
        e.dbg_rdata  = m_rd;
        if (cg) begin
            e.mem_we = cpu_we; e.mem_re = cpu_re && !cpu_we;
            e.mem_addr = cpu_addr; e.mem_wdata = cpu_wdata;
            if (e.mem_re) e.cpu_rdata = mref[cpu_addr];
        end
        if (dg) begin
            e.mem_we = dbg_we; e.mem_re = !dbg_we;
            e.mem_addr = dbg_addr; e.mem_wdata = dbg_wdata;
        end
        sb_q.push_back(e);
        m_rv = dg && !dbg_we;
        if (m_rv) m_rd = mref[dbg_addr];
        if (e.mem_we) mref[e.mem_addr] = e.mem_wdata;
        if (dg || !dbg_req) m_starve = 0;
        else if (cg && m_starve < SMAX) m_starve++;
        if (m_st != ST_COOL && dg && dbg_lock) begin
            m_burst++;
            m_st = (m_burst >= BMAX) ? ST_COOL : ST_LOCK;
        end else begin
            m_burst = 0;
            m_st = ST_ARB;
        end
    endtask

    task automatic sb_check();
        obs_t e, a;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e = sb_q.pop_front();
        a = {e.rst, cpu_stall, dbg_gnt, mem_re, mem_we, mem_addr, mem_wdata,
             cpu_rdata, dbg_rvalid, dbg_rdata};
        if (e.rst)
            chk("reset_outputs", {cpu_stall, dbg_gnt, mem_re, mem_we, dbg_rvalid, dbg_rdata}, '0);
        else
            chk("cycle_outputs", a, e);
        smp_stall = cpu_stall; smp_gnt = dbg_gnt; smp_rvalid = dbg_rvalid;
        smp_rdata = dbg_rdata; smp_cpu_rdata = cpu_rdata;
    endtask

    // Inputs are set at posedge+1; outputs are compared at the negedge.
    task automatic cyc();
        model_push();
        @(negedge CLK);
        sb_check();
        @(posedge CLK);
        #1;
        cyc_n++;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d; mref[a] = d;
        @(posedge CLK);
        #1;
        bd_we = 1'b0;
    endtask

    function automatic vec_t mkv(input logic cre, cwe, input logic [AW-1:0] caddr,
                                 input logic [DW-1:0] cwd, input logic dreq, dwe, dlk,
                                 input logic [AW-1:0] daddr, input logic [DW-1:0] dwd,
                                 input logic x_stall, x_gnt, x_rv, input logic [DW-1:0] x_rd);
        vec_t v;
        v.cre = cre; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.dreq = dreq; v.dwe = dwe; v.dlk = dlk; v.daddr = daddr; v.dwd = dwd;
        v.x_stall = x_stall; v.x_gnt = x_gnt; v.x_rv = x_rv; v.x_rd = x_rd;
        return v;
    endfunction

    // CPU access that retries while stalled, with random debug reads alongside.
    task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] rd);
        int n = 0;
        cpu_re = !we; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        do begin
            dbg_req  = ($urandom_range(0, 2) != 0);
            dbg_we   = 1'b0;
            dbg_lock = 1'b0;
            dbg_addr = AW'(32'h200 + $urandom_range(0, 15));
            cyc();
            n++;
        end while (smp_stall && n < 40);
        chk("fib_cpu_progress", smp_stall, 0);
        rd = smp_cpu_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] ra, rb, tmp, fa, fb, fc;
        logic          gp [0:127];
        logic          sp [0:127];
        int            nc, nw, idx, lead, r1, gap, r2;

        RSTn = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = '0; dbg_wdata = '0;
        m_reset();
        @(posedge CLK);
        #1;
        preload(10'h010, 32'h1111_0010);
        preload(10'h020, 32'hCAFE_0020);
        preload(10'h152, 32'h0BAD_0152);
        for (int i = 0; i < 16; i++) preload(AW'(32'h200 + i), 32'hEEEE_0000 + i);
        cyc();
        cyc();
        RSTn = 1'b1;

        // CPU-only reads, starvation of a debug read, then simple debug/CPU writes.
        for (int k = 0; k < 3; k++)
            tv[k] = mkv(1, 0, 10'h010, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 32'h0);
        for (int k = 3; k < 7; k++)
            tv[k] = mkv(1, 0, 10'h010, 0, 1, 0, 0, 10'h020, 0, 0, 0, 0, 32'h0);
        tv[7]  = mkv(1, 0, 10'h010, 0, 1, 0, 0, 10'h020, 0, 1, 1, 0, 32'h0);
        tv[8]  = mkv(1, 0, 10'h010, 0, 0, 0, 0, 10'h000, 0, 0, 0, 1, 32'hCAFE_0020);
        tv[9]  = mkv(0, 0, 10'h000, 0, 1, 1, 0, 10'h040, 32'hD0D0_0040, 0, 1, 0, 32'hCAFE_0020);
        tv[10] = mkv(0, 1, 10'h041, 32'hC0C0_0041, 0, 0, 0, 10'h000, 0, 0, 0, 0, 32'hCAFE_0020);
        for (int k = 0; k < 11; k++) begin
            cpu_re = tv[k].cre; cpu_we = tv[k].cwe; cpu_addr = tv[k].caddr; cpu_wdata = tv[k].cwd;
            dbg_req = tv[k].dreq; dbg_we = tv[k].dwe; dbg_lock = tv[k].dlk;
            dbg_addr = tv[k].daddr; dbg_wdata = tv[k].dwd;
            cyc();
            chk($sformatf("vec%0d_stall", k), smp_stall, tv[k].x_stall);
            chk($sformatf("vec%0d_gnt", k), smp_gnt, tv[k].x_gnt);
            chk($sformatf("vec%0d_rvalid", k), smp_rvalid, tv[k].x_rv);
            chk($sformatf("vec%0d_rdata", k), smp_rdata, tv[k].x_rd);
        end

        // Same-address collision: CPU lands first, debug overwrites later.
        cpu_re = 0; cpu_we = 1; cpu_addr = 10'h030; cpu_wdata = 32'hAAAA_0030;
        dbg_req = 1; dbg_we = 1; dbg_lock = 0; dbg_addr = 10'h030; dbg_wdata = 32'hBBBB_0030;
        cyc();
        chk("collide_dbg_gnt", smp_gnt, 0);
        chk("collide_ram_cpu", ram[10'h030], 32'hAAAA_0030);
        cpu_we = 0;
        cyc();
        chk("collide_dbg_gnt_later", smp_gnt, 1);
        chk("collide_ram_dbg", ram[10'h030], 32'hBBBB_0030);
        dbg_req = 0;

        // Locked 16-word debug burst against a CPU that always requests.
        cpu_re = 1; cpu_we = 0; cpu_addr = 10'h010;
        dbg_req = 1; dbg_we = 1; dbg_lock = 1;
        nc = 0; nw = 0;
        while (nc < 120 && nw < 16) begin
            dbg_addr = AW'(32'h100 + nw); dbg_wdata = 32'h5000 + nw;
            cyc();
            gp[nc] = smp_gnt; sp[nc] = smp_stall;
            if (smp_gnt) nw++;
            nc++;
        end
        dbg_req = 0; dbg_lock = 0; cpu_re = 0;
        chk("burst_all_granted", nw, 16);
        idx = 0; lead = 0; r1 = 0; gap = 0; r2 = 0;
        while (idx < nc && !gp[idx]) begin lead++; idx++; end
        while (idx < nc && gp[idx]) begin r1++; idx++; end
        chk("burst_cooldown_cpu_granted", sp[idx], 0);
        while (idx < nc && !gp[idx]) begin gap++; idx++; end
        while (idx < nc && gp[idx]) begin r2++; idx++; end
        chk("burst_lead", lead, 4);
        chk("burst_run1", r1, 8);
        chk("burst_gap", gap, 4);
        chk("burst_run2", r2, 8);
        for (int i = 0; i < 16; i++)
            chk($sformatf("burst_ram_%0d", i), ram[AW'(32'h100 + i)], 32'h5000 + i);

        // Reset asserted mid-burst (burst_cnt = 3, read data pending).
        cyc();
        dbg_req = 1; dbg_lock = 1; dbg_we = 1; dbg_addr = 10'h150; dbg_wdata = 32'h0001_5015;
        cyc();
        dbg_addr = 10'h151;
        cyc();
        dbg_we = 0; dbg_addr = 10'h020;
        cyc();
        dbg_we = 1; dbg_addr = 10'h152; dbg_wdata = 32'h1234_5678;
        #1;
        chk("midrst_pre_we", mem_we, 1);
        chk("midrst_pre_rvalid", dbg_rvalid, 1);
        RSTn = 1'b0;
        #1;
        chk("midrst_we", mem_we, 0);
        chk("midrst_gnt", dbg_gnt, 0);
        chk("midrst_rvalid", dbg_rvalid, 0);
        m_reset();
        dbg_req = 0; dbg_lock = 0; dbg_we = 0;
        @(posedge CLK);
        #1;
        cyc();
        RSTn = 1'b1;
        chk("midrst_ram_untouched", ram[10'h152], 32'h0BAD_0152);
        cpu_re = 1; cpu_addr = 10'h010;
        cyc();
        chk("postrst_cpu_stall", smp_stall, 0);
        chk("postrst_rvalid", smp_rvalid, 0);
        chk("postrst_cpu_rdata", smp_cpu_rdata, 32'h1111_0010);

        // Fibonacci program with random debug reads interleaved.
        cpu_op(1, 10'h200, 32'd0, tmp);
        cpu_op(1, 10'h201, 32'd1, tmp);
        for (int i = 2; i < 16; i++) begin
            cpu_op(0, AW'(32'h200 + i - 1), 0, ra);
            cpu_op(0, AW'(32'h200 + i - 2), 0, rb);
            cpu_op(1, AW'(32'h200 + i), ra + rb, tmp);
        end
        cpu_re = 0; cpu_we = 0; dbg_req = 0;
        cyc();
        fa = 0; fb = 1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fib_%0d", i), ram[AW'(32'h200 + i)], fa);
            fc = fa + fb; fa = fb; fb = fc;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
